// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency single-port memory between the fetch and data ports
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_ready_o,
  output logic                  if_stall_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_ready_o,
  output logic                  dm_stall_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  arb, if_elig, dm_elig, gnt, gnt_dm, fin;
  // owner 1 = DM; the port finishing in DONE sits out that cycle's arbitration, ties alternate on last grant
  always_comb begin
    arb        = state_q == S_IDLE || state_q == S_DONE;
    if_elig    = arb && if_req_i && !(state_q == S_DONE && !owner_q);
    dm_elig    = arb && dm_req_i && !(state_q == S_DONE && owner_q);
    gnt        = if_elig || dm_elig;
    gnt_dm     = dm_elig && (!if_elig || !last_q);
    fin        = state_q == S_WAIT && cnt_q == 4'd1;
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = (fin && !we_q && !owner_q) ? mem_rdata_i : if_rdata_q;
    dm_rdata_d = (fin && !we_q && owner_q) ? mem_rdata_i : dm_rdata_q;
    if (arb) begin
      state_d = gnt ? S_ISSUE : S_IDLE;
      if (gnt) begin
        owner_d = gnt_dm;
        last_d  = gnt_dm;
        we_d    = gnt_dm && dm_we_i;
        addr_d  = gnt_dm ? dm_addr_i : if_addr_i;
        wdata_d = gnt_dm ? dm_wdata_i : wdata_q;
      end
    end else if (state_q == S_ISSUE) begin
      state_d = S_WAIT;
      cnt_d   = 4'(LATENCY);
    end else begin
      state_d = fin ? S_DONE : S_WAIT;
      cnt_d   = cnt_q - 4'd1;
    end
  end
  // all state and datapath registers clear asynchronously, abandoning any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
  assign mem_en_o    = state_q == S_ISSUE;
  assign mem_we_o    = mem_en_o && we_q;
  assign if_ready_o  = state_q == S_DONE && !owner_q;
  assign dm_ready_o  = state_q == S_DONE && owner_q;
  assign if_stall_o  = reset && if_req_i && !if_ready_o;
  assign dm_stall_o  = reset && dm_req_i && !dm_ready_o;
  assign busy_o      = state_q != S_IDLE;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
endmodule
